// File: rtl/npc_bp.sv
// npc_bp: next-PC generation with a direct-mapped BTB, 2-bit saturating direction counters,
// ID-stage mispredict redirect and resolved-branch/mispredict counters.
module npc_bp #(
  parameter int          BTB_DEPTH = 16,
  parameter logic [31:0] RESET_PC  = 32'h1C00_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic        stall,
  input  logic        id_valid,
  input  logic        id_is_branch,
  input  logic [31:0] id_pc,
  input  logic        id_jump_taken,
  input  logic [31:0] id_jump_offset_ext,
  input  logic        id_pred_taken,
  input  logic [31:0] id_pred_target,
  output logic [31:0] if_pc,
  output logic [31:0] pc4,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        flush,
  output logic [31:0] br_cnt,
  output logic [31:0] mis_cnt
);
  localparam int IDX = $clog2(BTB_DEPTH);
  localparam int TW  = 30 - IDX;
  logic            v_mem   [BTB_DEPTH];
  logic [TW-1:0]   tag_mem [BTB_DEPTH];
  logic [31:0]     tgt_mem [BTB_DEPTH];
  logic [1:0]      ctr_mem [BTB_DEPTH];
  logic [IDX-1:0]  if_idx, id_idx;
  logic            hit, id_hit, resolve;
  logic [31:0]     br_target, next_pc;
  logic [1:0]      id_ctr;
  assign if_idx      = if_pc[IDX+1:2];
  assign id_idx      = id_pc[IDX+1:2];
  assign pc4         = if_pc + 32'd4;
  assign hit         = v_mem[if_idx] && (tag_mem[if_idx] == if_pc[31:IDX+2]);
  assign pred_taken  = hit & ctr_mem[if_idx][1];
  assign pred_target = pred_taken ? tgt_mem[if_idx] : pc4;
  assign id_hit      = v_mem[id_idx] && (tag_mem[id_idx] == id_pc[31:IDX+2]);
  assign id_ctr      = ctr_mem[id_idx];
  assign resolve     = id_valid & id_is_branch;
  assign br_target   = id_pc + id_jump_offset_ext;
  assign flush       = resolve & ((id_jump_taken != id_pred_taken) |
                                  (id_jump_taken & (br_target != id_pred_target)));
  always_comb begin
    next_pc = flush ? (id_jump_taken ? br_target : id_pc + 32'd4) : (stall ? if_pc : pred_target);
  end
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      if_pc   <= RESET_PC;
      br_cnt  <= '0;
      mis_cnt <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        v_mem[i]   <= 1'b0;
        ctr_mem[i] <= 2'b01;
      end
    end else begin
      if_pc <= next_pc;
      if (resolve) br_cnt <= br_cnt + 32'd1;
      if (flush) mis_cnt <= mis_cnt + 32'd1;
      if (resolve && id_hit)
        ctr_mem[id_idx] <= id_jump_taken ? (&id_ctr ? id_ctr : id_ctr + 2'd1)
                                         : (|id_ctr ? id_ctr - 2'd1 : id_ctr);
      else if (resolve && id_jump_taken) begin
        v_mem[id_idx]   <= 1'b1;
        ctr_mem[id_idx] <= 2'b10;
      end
    end
  end
  // tag/target need no reset: an entry is only trusted once its valid bit is set
  always_ff @(posedge cpu_clk) begin
    if (cpu_rstn && resolve && id_jump_taken) begin
      tag_mem[id_idx] <= id_pc[31:IDX+2];
      tgt_mem[id_idx] <= br_target;
    end
  end
endmodule

// File: tb/tb_npc_bp.sv
// tb_npc_bp: scenario tasks for npc_bp; expected fetch PCs are queued when stimulus is driven.
module tb_npc_bp;
  localparam int          D  = 16;
  localparam logic [31:0] RP = 32'h1C00_0000;
  logic        cpu_clk = 1'b0, cpu_rstn = 1'b1, stall = 1'b0;
  logic        id_valid = 1'b0, id_is_branch = 1'b0, id_jump_taken = 1'b0, id_pred_taken = 1'b0;
  logic [31:0] id_pc = '0, id_jump_offset_ext = '0, id_pred_target = '0;
  logic [31:0] if_pc, pc4, pred_target, br_cnt, mis_cnt;
  logic        pred_taken, flush;
  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e, exp_br = '0, exp_mis = '0;

  npc_bp #(.BTB_DEPTH(D), .RESET_PC(RP)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .stall(stall), .id_valid(id_valid),
    .id_is_branch(id_is_branch), .id_pc(id_pc), .id_jump_taken(id_jump_taken),
    .id_jump_offset_ext(id_jump_offset_ext), .id_pred_taken(id_pred_taken),
    .id_pred_target(id_pred_target), .if_pc(if_pc), .pc4(pc4), .pred_taken(pred_taken),
    .pred_target(pred_target), .flush(flush), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] off,
                    input logic pt, input logic [31:0] ptg, input logic st,
                    input logic fl, input logic [31:0] nxt);
    id_valid = 1'b1; id_is_branch = 1'b1; id_pc = pc; id_jump_taken = tk;
    id_jump_offset_ext = off; id_pred_taken = pt; id_pred_target = ptg; stall = st;
    exp_br++;
    if (fl) exp_mis++;
    exp_q.push_back(nxt);
  endtask

  task automatic idle();
    id_valid = 1'b0; id_is_branch = 1'b0; stall = 1'b0;
  endtask

  task automatic refetch(input logic [31:0] t);
    br(t - 32'd4, 1'b0, 32'd0, 1'b1, t, 1'b0, 1'b1, t);
    @(negedge cpu_clk);
    idle();
    e = exp_q.pop_front();
    checks++; if (if_pc !== e) begin errors++; $display("FAIL refetch if_pc: got %h want %h", if_pc, e); end
    #1;
  endtask

  task automatic test_reset();
    #1 cpu_rstn = 1'b0;
    #12;
    checks++; if (if_pc !== RP) begin errors++; $display("FAIL rst if_pc: got %h want %h", if_pc, RP); end
    checks++; if (pc4 !== RP + 32'd4) begin errors++; $display("FAIL rst pc4: got %h want %h", pc4, RP + 32'd4); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst pred_taken: got %b want 0", pred_taken); end
    checks++; if (pred_target !== RP + 32'd4) begin errors++; $display("FAIL rst pred_target: got %h want %h", pred_target, RP + 32'd4); end
    checks++; if (br_cnt !== 0 || mis_cnt !== 0) begin errors++; $display("FAIL rst cnt: got %h/%h want 0/0", br_cnt, mis_cnt); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst flush: got %b want 0", flush); end
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(RP + 32'(4 * i));
      @(negedge cpu_clk);
      e = exp_q.pop_front();
      checks++; if (if_pc !== e) begin errors++; $display("FAIL seq if_pc: got %h want %h", if_pc, e); end
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL seq pred_taken: got %b want 0", pred_taken); end
    end
  endtask

  task automatic test_alloc();
    br(32'h1C00_0010, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1C00_0050);
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL alloc flush: got %b want 1", flush); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alloc bypass pred_taken: got %b want 0", pred_taken); end
    @(negedge cpu_clk);
    idle();
    e = exp_q.pop_front();
    checks++; if (if_pc !== e) begin errors++; $display("FAIL alloc if_pc: got %h want %h", if_pc, e); end
    checks++; if (br_cnt !== 32'd1 || mis_cnt !== 32'd1) begin errors++; $display("FAIL alloc cnt: got %0d/%0d want 1/1", br_cnt, mis_cnt); end
  endtask

  task automatic test_predict_hit();
    refetch(32'h1C00_0010);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL hit pred_taken: got %b want 1", pred_taken); end
    checks++; if (pred_target !== 32'h1C00_0050) begin errors++; $display("FAIL hit pred_target: got %h want 1c000050", pred_target); end
    br(32'h1C00_0010, 1'b1, 32'h40, 1'b1, 32'h1C00_0050, 1'b1, 1'b0, 32'h1C00_0010);
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL hit flush: got %b want 0", flush); end
    @(negedge cpu_clk);
    idle();
    e = exp_q.pop_front();
    checks++; if (if_pc !== e) begin errors++; $display("FAIL hit if_pc: got %h want %h", if_pc, e); end
    checks++; if (br_cnt !== exp_br || mis_cnt !== exp_mis) begin errors++; $display("FAIL hit cnt: got %0d/%0d want %0d/%0d", br_cnt, mis_cnt, exp_br, exp_mis); end
  endtask

  task automatic test_mispredict();
    for (int k = 0; k < 2; k++) begin
      br(32'h1C00_0010, 1'b0, 32'h40, 1'b1, 32'h1C00_0050, 1'b1, 1'b1, 32'h1C00_0014);
      #1;
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mis%0d flush: got %b want 1", k, flush); end
      @(negedge cpu_clk);
      idle();
      e = exp_q.pop_front();
      checks++; if (if_pc !== e) begin errors++; $display("FAIL mis%0d if_pc: got %h want %h", k, if_pc, e); end
      refetch(32'h1C00_0010);
      checks++; if (pred_taken !== (k == 0)) begin errors++; $display("FAIL mis%0d pred_taken: got %b want %b", k, pred_taken, k == 0); end
    end
    checks++; if (pred_target !== 32'h1C00_0014) begin errors++; $display("FAIL mis pred_target: got %h want 1c000014", pred_target); end
    checks++; if (br_cnt !== exp_br || mis_cnt !== exp_mis) begin errors++; $display("FAIL mis cnt: got %0d/%0d want %0d/%0d", br_cnt, mis_cnt, exp_br, exp_mis); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h1C00_0010);
      @(negedge cpu_clk);
      e = exp_q.pop_front();
      checks++; if (if_pc !== e) begin errors++; $display("FAIL stall%0d if_pc: got %h want %h", i, if_pc, e); end
    end
    stall = 1'b0;
  endtask

  task automatic test_alias();
    br(32'h1C00_0010 + 32'(4 * D), 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1C00_0090);
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL alias flush: got %b want 1", flush); end
    @(negedge cpu_clk);
    idle();
    e = exp_q.pop_front();
    checks++; if (if_pc !== e) begin errors++; $display("FAIL alias if_pc: got %h want %h", if_pc, e); end
    refetch(32'h1C00_0010);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias old pred_taken: got %b want 0", pred_taken); end
    refetch(32'h1C00_0050);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h1C00_0090) begin errors++; $display("FAIL alias new pred: got %b/%h want 1/1c000090", pred_taken, pred_target); end
    checks++; if (br_cnt !== exp_br || mis_cnt !== exp_mis) begin errors++; $display("FAIL alias cnt: got %0d/%0d want %0d/%0d", br_cnt, mis_cnt, exp_br, exp_mis); end
  endtask

  task automatic test_reset_mid();
    br(32'h1C00_0050, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    #2 cpu_rstn = 1'b0;
    #1;
    void'(exp_q.pop_front());
    exp_br = '0; exp_mis = '0;
    checks++; if (if_pc !== RP) begin errors++; $display("FAIL mid if_pc: got %h want %h", if_pc, RP); end
    checks++; if (br_cnt !== 0 || mis_cnt !== 0) begin errors++; $display("FAIL mid cnt: got %0d/%0d want 0/0", br_cnt, mis_cnt); end
    idle();
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    exp_q.push_back(RP + 32'd4);
    @(negedge cpu_clk);
    e = exp_q.pop_front();
    checks++; if (if_pc !== e) begin errors++; $display("FAIL mid advance if_pc: got %h want %h", if_pc, e); end
    refetch(32'h1C00_0050);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL mid btb cleared pred_taken: got %b want 0", pred_taken); end
    checks++; if (br_cnt !== exp_br || mis_cnt !== exp_mis) begin errors++; $display("FAIL mid cnt2: got %0d/%0d want %0d/%0d", br_cnt, mis_cnt, exp_br, exp_mis); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_alloc();
    test_predict_hit();
    test_mispredict();
    test_stall();
    test_alias();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
